// File: rtl/ci_pkg.sv
// Shared types and constants for the custom-instruction initiator.
package ci_pkg;

  localparam int CI_DATA_W = 32;
  localparam int CI_N_W    = 8;

  localparam logic [CI_DATA_W-1:0] CI_ERR_RESULT = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } ci_state_e;

endpackage

// File: rtl/ci_cycle_counter.sv
// Saturating cycle counter with synchronous clear and an optional terminal-count flag.
module ci_cycle_counter #(
  parameter int LAT_W    = 16,
  parameter bit HAS_TC   = 1'b0,
  parameter int TC_VALUE = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [LAT_W-1:0] o_count,
  output logic [LAT_W-1:0] o_count_inc,
  output logic             o_tc
);

  logic [LAT_W-1:0] r_count;

  assign o_count     = r_count;
  assign o_count_inc = (r_count == {LAT_W{1'b1}}) ? r_count : r_count + 1'b1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_count <= '0;
    else if (i_clr) r_count <= '0;
    else if (i_en)  r_count <= o_count_inc;
  end

  // tc flags the cycle in which the count reaches TC_VALUE, so the reported
  // latency on expiry equals TC_VALUE exactly.
  generate
    if (HAS_TC) begin : g_tc
      assign o_tc = i_en && (o_count_inc == LAT_W'(TC_VALUE));
    end else begin : g_no_tc
      assign o_tc = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/ci_initiator.sv
// Multi-cycle custom-instruction initiator: one CI transaction per request, result + latency back.
// Optional abort of hung transactions when CI_INIT_TIMEOUT_EN is defined.
module ci_initiator
  import ci_pkg::*;
#(
  parameter int LAT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [CI_DATA_W-1:0] i_req_dataa,
  input  logic [CI_DATA_W-1:0] i_req_datab,
  input  logic [CI_N_W-1:0]    i_req_n,
  output logic                 o_ci_clk_en,
  output logic                 o_ci_start,
  output logic [CI_DATA_W-1:0] o_ci_dataa,
  output logic [CI_DATA_W-1:0] o_ci_datab,
  output logic [CI_N_W-1:0]    o_ci_n,
  input  logic                 i_ci_done,
  input  logic [CI_DATA_W-1:0] i_ci_result,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [CI_DATA_W-1:0] o_rsp_result,
  output logic                 o_rsp_err,
  output logic [LAT_W-1:0]     o_rsp_latency
);

  ci_state_e            r_state, w_state_nxt;
  logic                 r_ci_start, r_ci_clk_en, r_rsp_valid;
  logic [CI_DATA_W-1:0] r_ci_dataa, r_ci_datab, r_rsp_result;
  logic [CI_N_W-1:0]    r_ci_n;
  logic [LAT_W-1:0]     r_rsp_latency;
  logic                 w_cnt_clr, w_cnt_en, w_tc;
  logic [LAT_W-1:0]     w_count, w_count_inc;

`ifdef CI_INIT_TIMEOUT_EN
  localparam bit HAS_TIMEOUT = 1'b1;
`else
  localparam bit HAS_TIMEOUT = 1'b0;
`endif

  ci_cycle_counter #(
    .LAT_W    (LAT_W),
    .HAS_TC   (HAS_TIMEOUT),
    .TC_VALUE (TIMEOUT_CYCLES)
  ) u_cnt (
    .i_clk       (i_clk),
    .i_rst_n     (i_reset_n),
    .i_clr       (w_cnt_clr),
    .i_en        (w_cnt_en),
    .o_count     (w_count),
    .o_count_inc (w_count_inc),
    .o_tc        (w_tc)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    case (r_state)
      IDLE:  if (i_req_valid) w_state_nxt = ISSUE;
      ISSUE: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        w_cnt_en = 1'b1;
        if (i_ci_done || w_tc) w_state_nxt = RESP;
      end
      RESP:  if (i_rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state itself.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= IDLE;
      r_ci_start    <= 1'b0;
      r_ci_clk_en   <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_ci_dataa    <= '0;
      r_ci_datab    <= '0;
      r_ci_n        <= '0;
      r_rsp_result  <= '0;
      r_rsp_latency <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ci_start  <= (w_state_nxt == ISSUE);
      r_ci_clk_en <= (w_state_nxt == ISSUE) || (w_state_nxt == WAIT);
      r_rsp_valid <= (w_state_nxt == RESP);
      if (r_state == IDLE && i_req_valid) begin
        r_ci_dataa <= i_req_dataa;
        r_ci_datab <= i_req_datab;
        r_ci_n     <= i_req_n;
      end
      if (r_state == WAIT && i_ci_done) begin
        r_rsp_result  <= i_ci_result;
        r_rsp_latency <= w_count_inc;
      end else if (r_state == WAIT && w_tc) begin
        r_rsp_result  <= CI_ERR_RESULT;
        r_rsp_latency <= w_count_inc;
      end
    end
  end

`ifdef CI_INIT_TIMEOUT_EN
  logic r_rsp_err;

  // Done has priority over expiry in the same cycle.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                     r_rsp_err <= 1'b0;
    else if (r_state == WAIT && i_ci_done) r_rsp_err <= 1'b0;
    else if (r_state == WAIT && w_tc)   r_rsp_err <= 1'b1;
  end

  assign o_rsp_err = r_rsp_err;
`else
  assign o_rsp_err = 1'b0;
`endif

  assign o_req_ready   = (r_state == IDLE);
  assign o_ci_start    = r_ci_start;
  assign o_ci_clk_en   = r_ci_clk_en;
  assign o_ci_dataa    = r_ci_dataa;
  assign o_ci_datab    = r_ci_datab;
  assign o_ci_n        = r_ci_n;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_result  = r_rsp_result;
  assign o_rsp_latency = r_rsp_latency;

endmodule

// File: tb/tb_ci_initiator.sv
// Directed bench for ci_initiator; timeout cases run only when CI_INIT_TIMEOUT_EN is defined.
module tb_ci_initiator;

  localparam int LAT_W = 16;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready;
  logic [31:0] req_dataa, req_datab;
  logic [7:0]  req_n;
  logic        ci_clk_en, ci_start;
  logic [31:0] ci_dataa, ci_datab;
  logic [7:0]  ci_n;
  logic        ci_done;
  logic [31:0] ci_result;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_err;
  logic [LAT_W-1:0] rsp_latency;

  int n_chk  = 0;
  int n_fail = 0;
  int start_cnt = 0;

  ci_initiator #(.LAT_W(LAT_W), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_dataa   (req_dataa),
    .i_req_datab   (req_datab),
    .i_req_n       (req_n),
    .o_ci_clk_en   (ci_clk_en),
    .o_ci_start    (ci_start),
    .o_ci_dataa    (ci_dataa),
    .o_ci_datab    (ci_datab),
    .o_ci_n        (ci_n),
    .i_ci_done     (ci_done),
    .i_ci_result   (ci_result),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_result  (rsp_result),
    .o_rsp_err     (rsp_err),
    .o_rsp_latency (rsp_latency)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ci_start === 1'b1) start_cnt++;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_start"},     ci_start, 0);
    chk({tag, "_clk_en"},    ci_clk_en, 0);
    chk({tag, "_dataa"},     ci_dataa, 0);
    chk({tag, "_datab"},     ci_datab, 0);
    chk({tag, "_n"},         ci_n, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_res"},   rsp_result, 0);
    chk({tag, "_rsp_err"},   rsp_err, 0);
    chk({tag, "_rsp_lat"},   rsp_latency, 0);
  endtask

  // Drive a request, leave the bench one cycle into ISSUE.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [7:0] n);
    @(posedge clk); #1;
    chk("idle_req_ready", req_ready, 1);
    req_valid = 1'b1; req_dataa = a; req_datab = b; req_n = n;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("issue_start", ci_start, 1);
    chk("issue_clk_en", ci_clk_en, 1);
    chk("issue_req_ready", req_ready, 0);
    chk("issue_dataa", ci_dataa, a);
    chk("issue_datab", ci_datab, b);
    chk("issue_n", ci_n, n);
  endtask

  task automatic do_txn(input logic [31:0] a, input logic [31:0] b, input logic [7:0] n,
                        input int nlat, input logic [31:0] res, input bit stale, input int bp);
    int s0;
    s0 = start_cnt;
    issue(a, b, n);
    if (stale) begin ci_done = 1'b1; ci_result = 32'h0BAD0BAD; end
    for (int i = 1; i <= nlat; i++) begin
      @(posedge clk); #1;
      ci_done   = (i == nlat);
      ci_result = (i == nlat) ? res : 32'h0BAD0BAD;
      if (i == 1) chk("wait_start_low", ci_start, 0);
      chk("wait_clk_en", ci_clk_en, 1);
      chk("wait_no_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    ci_done = 1'b0;
    rsp_ready = (bp == 0);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_result", rsp_result, res);
    chk("rsp_latency", rsp_latency, nlat);
    chk("rsp_err", rsp_err, 0);
    chk("rsp_clk_en", ci_clk_en, 0);
    chk("one_start", start_cnt - s0, 1);
    for (int j = 0; j < bp; j++) begin
      @(posedge clk); #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_result", rsp_result, res);
      chk("bp_latency", rsp_latency, nlat);
      chk("bp_req_ready", req_ready, 0);
      if (j == bp - 1) rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("post_req_ready", req_ready, 1);
    chk("post_rsp_valid", rsp_valid, 0);
    rsp_ready = 1'b1;
  endtask

`ifdef CI_INIT_TIMEOUT_EN
  task automatic do_timeout();
    int k;
    bit seen;
    k = 0; seen = 0;
    issue(32'h1, 32'h2, 8'h7);
    ci_done = 1'b0;
    while (k < 40 && !seen) begin
      @(posedge clk); #1;
      k++;
      seen = rsp_valid;
    end
    chk("tmo_seen", seen, 1);
    chk("tmo_cycles", k, TMO + 1);
    chk("tmo_err", rsp_err, 1);
    chk("tmo_result", rsp_result, 32'hDEADBEEF);
    chk("tmo_latency", rsp_latency, TMO);
    @(posedge clk); #1;
    chk("tmo_back_idle", req_ready, 1);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    reset_n = 1'b0; req_valid = 1'b0; req_dataa = '0; req_datab = '0; req_n = '0;
    ci_done = 1'b0; ci_result = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    chk("idle_no_start", start_cnt, 0);

    do_txn(32'd12, 32'd8, 8'd3, 4, 32'd4, 1'b0, 0);
    do_txn(32'hA5A5A5A5, 32'h5A5A5A5A, 8'hFF, 3, 32'hCAFEF00D, 1'b0, 10);
    do_txn(32'h11, 32'h22, 8'h01, 6, 32'h55, 1'b1, 0);
    do_txn(32'hFFFFFFFF, 32'h0, 8'h80, 1, 32'h12345678, 1'b0, 0);
    do_txn(32'h3, 32'h4, 8'h10, TMO, 32'h77, 1'b0, 0);
`ifdef CI_INIT_TIMEOUT_EN
    do_timeout();
`endif

    // Reset in the middle of WAIT drops the transaction.
    issue(32'h99, 32'h98, 8'h42);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(posedge clk); #1 ci_done = 1'b1; ci_result = 32'hBEEF;
    @(posedge clk); #1 ci_done = 1'b0; reset_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1;
    end
    chk("midrst_no_rsp", seen, 0);
    do_txn(32'd7, 32'd9, 8'd5, 2, 32'd63, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ci_initiator.md
# ci_initiator

Initiator side of the Nios II multi-cycle custom-instruction interface. The block accepts operand requests on a valid/ready port and drives one custom-instruction transaction per request (clk_en, start, dataa, datab, n) into a CI slave. It then waits for the slave's done pulse and returns the result, the measured latency and an error flag on a valid/ready response port. It replaces processor-issued CI calls in hardware-driven datapaths and benches, and it characterises slave latency.

## Interface
- LAT_W, 16: width of the latency counter and of rsp_latency.
- TIMEOUT_CYCLES, 1024: number of WAIT cycles before a transaction is aborted; used only with CI_INIT_TIMEOUT_EN.
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_dataa, req_datab  in  32  operands.
- req_n  in  8  CI extension/opcode field.
- ci_clk_en  out  1  CI clock enable.
- ci_start  out  1  CI start, one-cycle pulse.
- ci_dataa, ci_datab  out  32  operands to the slave.
- ci_n  out  8  opcode to the slave.
- ci_done  in  1  slave completion pulse.
- ci_result  in  32  slave result; valid when ci_done=1.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  32  captured result.
- rsp_err  out  1  transaction timed out.
- rsp_latency  out  LAT_W  start-to-done cycle count.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - req_ready=1.
  - On req_valid, latch the operands and n into the ci_* registers and go to ISSUE.
- ISSUE (exactly 1 cycle)
  - ci_start=1, ci_clk_en=1.
  - Clear the cycle counter and go to WAIT.
- WAIT
  - ci_clk_en=1, ci_start=0.
  - The counter increments each cycle and saturates at 2^LAT_W-1.
  - When ci_done=1 is sampled: capture rsp_result=ci_result, rsp_latency=counter+1, rsp_err=0, then go to RESP.
- RESP
  - rsp_valid=1; rsp_* are held stable and ci_clk_en=0.
  - On rsp_ready, go to IDLE.
- The ci_dataa, ci_datab and ci_n registers hold their values from ISSUE until the next accepted request.
- ci_done is ignored in IDLE, ISSUE and RESP. A stale done from a prior transaction never completes a new one.
- req_ready=0 in every state except IDLE. A request is never accepted in the same cycle that a response is consumed.
- Latency definition: a slave asserting done N cycles after the cycle in which start was high gives rsp_latency=N.

## Timing
- Reset values: req_ready=1 once reset is released (IDLE). ci_start=0, ci_clk_en=0, ci_dataa=0, ci_datab=0, ci_n=0, rsp_valid=0, rsp_result=0, rsp_err=0, rsp_latency=0.
- Assertion of reset_n mid-transaction returns the block to IDLE immediately. The in-flight transaction is dropped and no response is produced.
- Request accepted at edge k gives ci_start=1 in cycle k+1 and WAIT from cycle k+2.
- ci_done sampled at edge m gives rsp_valid=1 from cycle m+1.
- Minimum request-to-request spacing is N+3 cycles with rsp_ready held at 1.
- Every output is registered, with one exception: req_ready is decoded from the state.

## Configuration
- CI_INIT_TIMEOUT_EN defined
  - In WAIT, when the counter reaches TIMEOUT_CYCLES with no done, go to RESP with rsp_err=1, rsp_result=32'hDEADBEEF and rsp_latency=TIMEOUT_CYCLES.
  - If done and expiry occur in the same cycle, done wins and rsp_err=0.
- CI_INIT_TIMEOUT_EN undefined
  - WAIT lasts until done, with no upper bound.
  - rsp_err is tied to 0 and the timeout compare logic is absent.

## Structure
- Package ci_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the CI_ERR_RESULT=32'hDEADBEEF constant;
  - the CI operand width (32) and opcode width (8) constants.
- Sub-module ci_cycle_counter: clear, enable, a saturating LAT_W-bit count and a terminal-count compare. It serves both the latency measurement and the timeout.

## Test plan
- Reset, then idle: all outputs at their reset values and req_ready=1; ci_start never pulses without a request.
- Request dataa=12, datab=8, n=3 to a slave BFM with done at N=4 and result=4: exactly one ci_start pulse with ci_dataa=12, ci_datab=8, ci_n=3; response rsp_result=4, rsp_latency=4, rsp_err=0.
- Response backpressure: hold rsp_ready=0 for 10 cycles. rsp_valid and rsp_* stay stable and req_ready=0 throughout; after the accept, req_ready=1 the next cycle.
- Stale done: the BFM pulses done during ISSUE, then again at N=6 with result=0x55. The first pulse is ignored; the response is 0x55 with latency 6.
- Timeout, with CI_INIT_TIMEOUT_EN defined and TIMEOUT_CYCLES=16: the BFM never asserts done. The response arrives with rsp_err=1, rsp_result=0xDEADBEEF and rsp_latency=16. A variant with done at cycle 16 returns rsp_err=0.
- Mid-WAIT reset: assert reset_n=0 for 2 cycles. Outputs return to reset values asynchronously and no response is produced. A following request completes normally.
